// File: rtl/reg_file_dump_ctrl.sv
// Debug register-file dump sequencer: while the pipeline is halted, walks registers
// 0..NREGS-1 over read port 1 and streams each word MSB-byte-first on a valid/ready byte port.
module reg_file_dump_ctrl #(
  parameter int len   = 32,
  parameter int NB    = 5,
  parameter int NREGS = 32,
  parameter int NB_TX = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_pipe_halted,
  output logic             o_rf_sel,
  output logic [NB-1:0]    o_rf_read_addr,
  input  logic [len-1:0]   i_rf_read_data,
  output logic [NB_TX-1:0] o_tx_data,
  output logic             o_tx_valid,
  input  logic             i_tx_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_abort
);

  localparam int NBYTES = len / NB_TX;
  localparam int BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_HALT, S_ADDR, S_LATCH, S_SEND, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [NB-1:0]    idx_q, idx_d;
  logic [BCW-1:0]   bcnt_q, bcnt_d;
  logic [len-1:0]   shift_q, shift_d;
  logic             abort_q, abort_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      bcnt_q  <= '0;
      shift_q <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      abort_q <= abort_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    abort_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_WAIT_HALT;
          idx_d   = '0;
        end
      end
      S_WAIT_HALT: if (i_pipe_halted) state_d = S_ADDR;
      // Halt is only checked here, at a word boundary, so a word is never cut short.
      S_ADDR: begin
        if (!i_pipe_halted) begin
          state_d = S_IDLE;
          abort_d = 1'b1;
        end else begin
          state_d = S_LATCH;
        end
      end
      S_LATCH: begin
        shift_d = i_rf_read_data;
        bcnt_d  = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (i_tx_ready) begin
          shift_d = shift_q << NB_TX;
          bcnt_d  = bcnt_q + BCW'(1);
          if (bcnt_q == BCW'(NBYTES - 1)) begin
            if (idx_q == NB'(NREGS - 1)) begin
              state_d = S_DONE;
            end else begin
              idx_d   = idx_q + NB'(1);
              state_d = S_ADDR;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign o_rf_sel       = (state_q == S_ADDR) || (state_q == S_LATCH) || (state_q == S_SEND);
  assign o_rf_read_addr = idx_q;
  assign o_tx_valid     = (state_q == S_SEND);
  assign o_tx_data      = (state_q == S_SEND) ? shift_q[len-1 -: NB_TX] : '0;
  assign o_busy         = (state_q != S_IDLE);
  assign o_done         = (state_q == S_DONE);
  assign o_abort        = abort_q;

endmodule

// File: tb/tb_reg_file_dump_ctrl.sv
// Directed bench for reg_file_dump_ctrl: register-file model, negedge byte monitor,
// immediate-assertion checks against hand-computed dump streams and latencies.
module tb_reg_file_dump_ctrl;

  logic        clk = 1'b0;
  logic        i_rst, i_start, i_pipe_halted, i_tx_ready;
  logic        o_rf_sel, o_tx_valid, o_busy, o_done, o_abort;
  logic [4:0]  o_rf_read_addr;
  logic [31:0] i_rf_read_data;
  logic [7:0]  o_tx_data;

  reg_file_dump_ctrl dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_pipe_halted(i_pipe_halted),
    .o_rf_sel(o_rf_sel), .o_rf_read_addr(o_rf_read_addr), .i_rf_read_data(i_rf_read_data),
    .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
    .o_busy(o_busy), .o_done(o_done), .o_abort(o_abort)
  );

  always #5 clk = ~clk;

  // Registered-read register file: data valid one cycle after the address.
  logic [31:0] rf [32];
  always @(posedge clk) i_rf_read_data <= rf[o_rf_read_addr];

  int compared = 0, failed = 0;
  int cyc = 0;
  logic [7:0] q[$];
  int done_cnt = 0, abort_cnt = 0, stall_viol = 0;
  int start_cyc = 0, done_cyc = 0, first_vld = -1;
  bit hold_v = 0;
  logic [7:0] hold_d = '0;
  bit rand_rdy = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_tx_valid && i_tx_ready) q.push_back(o_tx_data);
    if (!i_rst && hold_v && (!o_tx_valid || o_tx_data !== hold_d)) stall_viol++;
    hold_v = o_tx_valid && !i_tx_ready && !i_rst;
    hold_d = o_tx_data;
    if (o_done) begin done_cnt++; done_cyc = cyc; end
    if (o_abort) abort_cnt++;
    if (i_start && !o_busy && !i_rst) start_cyc = cyc;
    if (o_tx_valid && first_vld < 0) first_vld = cyc;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick(1);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < max; i++) begin
      i_tx_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      tick(1);
      if (done_cnt != d0) break;
    end
    i_tx_ready = 1'b1;
    chk({tag, "_done_seen"}, done_cnt - d0, 1);
  endtask

  // Expected stream: r[k] = A5000000+k, MSB byte first.
  task automatic check_stream(input string tag);
    logic [31:0] w;
    logic [7:0]  obs;
    chk({tag, "_nbytes"}, q.size(), 128);
    for (int k = 0; k < 32; k++) begin
      w = 32'hA500_0000 + k;
      for (int b = 0; b < 4; b++) begin
        obs = (k * 4 + b < q.size()) ? q[k*4+b] : 8'hxx;
        chk($sformatf("%s_r%0d_b%0d", tag, k, b), obs, w[31-8*b -: 8]);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 32; k++) rf[k] = 32'hA500_0000 + k;
    i_rst = 1'b1; i_start = 1'b0; i_pipe_halted = 1'b1; i_tx_ready = 1'b1;
    tick(3);
    chk("rst_sel",   o_rf_sel, 0);
    chk("rst_addr",  o_rf_read_addr, 0);
    chk("rst_data",  o_tx_data, 0);
    chk("rst_valid", o_tx_valid, 0);
    chk("rst_busy",  o_busy, 0);
    chk("rst_done",  o_done, 0);
    chk("rst_abort", o_abort, 0);
    i_rst = 1'b0;
    tick(2);

    // 1: full dump, ready always high, latency checks
    q.delete(); first_vld = -1;
    pulse_start();
    wait_done("t1", 400);
    check_stream("t1");
    chk("t1_first_valid_lat", first_vld - start_cyc, 4);
    chk("t1_done_lat", done_cyc - start_cyc, 194);
    chk("t1_sel_after", o_rf_sel, 0);
    chk("t1_busy_after", o_busy, 0);

    // 2: random ready stalls
    q.delete(); rand_rdy = 1; stall_viol = 0;
    pulse_start();
    wait_done("t2", 2000);
    rand_rdy = 0;
    check_stream("t2");
    chk("t2_stall_hold_viol", stall_viol, 0);

    // 3: start before halt
    q.delete(); i_pipe_halted = 1'b0;
    pulse_start();
    tick(10);
    chk("t3_no_tx", q.size(), 0);
    chk("t3_sel_low", o_rf_sel, 0);
    chk("t3_busy", o_busy, 1);
    i_pipe_halted = 1'b1;
    wait_done("t3", 400);
    check_stream("t3");

    // 4: halt lost during r5 -> r5 completes, then abort
    q.delete();
    begin
      int a0, d0;
      a0 = abort_cnt; d0 = done_cnt;
      pulse_start();
      for (int i = 0; i < 400 && q.size() < 21; i++) tick(1);
      i_pipe_halted = 1'b0;
      for (int i = 0; i < 40 && abort_cnt == a0; i++) tick(1);
      tick(3);
      chk("t4_abort_cnt", abort_cnt - a0, 1);
      chk("t4_nbytes", q.size(), 24);
      chk("t4_last_byte", q.size() == 24 ? q[23] : 8'hxx, 8'h05);
      chk("t4_no_done", done_cnt - d0, 0);
      chk("t4_busy", o_busy, 0);
      chk("t4_sel", o_rf_sel, 0);
    end
    i_pipe_halted = 1'b1;
    tick(2);

    // 5: second start mid-dump ignored
    q.delete();
    begin
      int d0;
      d0 = done_cnt;
      pulse_start();
      tick(50);
      pulse_start();
      wait_done("t5", 400);
      tick(20);
      check_stream("t5");
      chk("t5_one_done", done_cnt - d0, 1);
      chk("t5_idle", o_busy, 0);
    end

    // 6: reset during SEND of r3, then fresh dump from r0
    q.delete();
    begin
      int a0, d0;
      a0 = abort_cnt; d0 = done_cnt;
      pulse_start();
      for (int i = 0; i < 400 && q.size() < 13; i++) tick(1);
      chk("t6_in_send", o_tx_valid, 1);
      i_rst = 1'b1;
      tick(1);
      chk("t6_sel",   o_rf_sel, 0);
      chk("t6_valid", o_tx_valid, 0);
      chk("t6_data",  o_tx_data, 0);
      chk("t6_addr",  o_rf_read_addr, 0);
      chk("t6_busy",  o_busy, 0);
      chk("t6_done",  o_done, 0);
      chk("t6_abort", o_abort, 0);
      i_rst = 1'b0;
      tick(3);
      chk("t6_no_done",  done_cnt - d0, 0);
      chk("t6_no_abort", abort_cnt - a0, 0);
    end
    q.delete();
    pulse_start();
    wait_done("t6", 400);
    check_stream("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
